// File: rtl/cpu_uart_bridge_pkg.sv
// Shared UART definitions: the bit-phase state enum, frame width and RX FIFO depth.
package lib_uart;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } UART_STATE;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned FIFO_DEPTH = 4;

endpackage

// File: rtl/cpu_uart_bridge_if.sv
// CPU-side handshake of the UART bridge: write request/data/busy and read data/irq/ack.
interface cpu_uart_bridge_if;

    logic        w_req;
    logic [31:0] w_data;
    logic        w_busy;
    logic [31:0] r_data;
    logic        irr;
    logic        ack;

    modport master (
        output w_req, w_data, ack,
        input  w_busy, r_data, irr
    );

    modport slave (
        input  w_req, w_data, ack,
        output w_busy, r_data, irr
    );

endinterface

// File: rtl/cpu_uart_bridge_rx.sv
// UART receive deserializer: 2-flop synchronizer, mid-bit sampling FSM and a one-cycle
// byte-valid strobe; framing errors are swallowed here.
module uart_rx
    import lib_uart::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic           sync1_q;
    logic           sync2_q;
    logic           prev_q;
    UART_STATE      state_q;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     idx_q;
    logic [7:0]     shift_q;
    logic           ferr_q;
    logic           valid_q;
    logic [7:0]     byte_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
            byte_q  <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    // Half-bit check rejects glitches and aligns later samples to mid-bit.
                    if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= sync2_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (idx_q == 3'(FRAME_BITS - 1)) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    // After a framing error, hold here until the line returns high.
                    if (ferr_q) begin
                        if (sync2_q) begin
                            ferr_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_o  = byte_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/cpu_uart_bridge.sv
// CPU-to-UART bridge: 8N1 transmitter, receive holding register and CPU handshake.
// Define UART_RX_FIFO_EN to replace the holding register with a 4-entry receive FIFO.
module cpu_uart_bridge
    import lib_uart::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst,
    cpu_uart_bridge_if.slave bus,
    output logic             uart_tx,
    input  logic             uart_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    UART_STATE      tx_state_q;
    logic [CW-1:0]  tx_cnt_q;
    logic [2:0]     tx_idx_q;
    logic [7:0]     tx_data_q;
    logic           tx_q;
    logic           busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (tx_state_q)
                IDLE: begin
                    if (bus.w_req && !busy_q) begin
                        tx_data_q  <= bus.w_data[7:0];
                        tx_state_q <= START;
                        tx_cnt_q   <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_q       <= tx_data_q[0];
                        tx_state_q <= DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'(FRAME_BITS - 1)) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= STOP;
                        end else begin
                            tx_idx_q <= tx_idx_q + 1'b1;
                            tx_q     <= tx_data_q[tx_idx_q + 3'd1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    assign uart_tx    = tx_q;
    assign bus.w_busy = busy_q;

    logic       rx_valid;
    logic [7:0] rx_byte;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (uart_rx),
        .byte_o (rx_byte),
        .valid_o(rx_valid)
    );

`ifdef UART_RX_FIFO_EN
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;

    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            push;
    logic            pop;

    assign push = rx_valid && (count_q != CNTW'(FIFO_DEPTH));
    assign pop  = bus.ack && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rx_byte;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.r_data = (count_q != '0) ? {24'h0, fifo_q[rd_ptr_q]} : '0;
    assign bus.irr    = (count_q != '0);
`else
    logic [7:0] rdata_q;
    logic       irr_q;

    // A completing byte takes priority over a same-cycle ack and overwrites any unread byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            irr_q   <= 1'b0;
        end else if (rx_valid) begin
            rdata_q <= rx_byte;
            irr_q   <= 1'b1;
        end else if (bus.ack && irr_q) begin
            irr_q <= 1'b0;
        end
    end

    assign bus.r_data = {24'h0, rdata_q};
    assign bus.irr    = irr_q;
`endif

endmodule

// File: tb/tb_cpu_uart_bridge.sv
// Self-checking bench for cpu_uart_bridge at CLKS_PER_BIT=8; honours UART_RX_FIFO_EN.
module tb_cpu_uart_bridge;

    localparam int unsigned CPB = 8;

    logic clk = 1'b0;
    logic rst;
    logic uart_tx;
    logic uart_rx;

    cpu_uart_bridge_if bus_if();

    cpu_uart_bridge #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if.slave),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference receive model: a byte queue (FIFO build) or last-byte/pending pair.
    logic [7:0] mq[$];
    logic [7:0] m_r;
    logic       m_irr;

    typedef struct {
        bit          is_frame;
        logic [7:0]  data;
        logic        stop;
        logic [31:0] exp_r;
        logic        exp_irr;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_r   = 8'h00;
        m_irr = 1'b0;
    endfunction

    function automatic void model_rx(input logic [7:0] b);
`ifdef UART_RX_FIFO_EN
        if (mq.size() < 4) mq.push_back(b);
`else
        m_r   = b;
        m_irr = 1'b1;
`endif
    endfunction

    function automatic void model_ack();
`ifdef UART_RX_FIFO_EN
        if (mq.size() > 0) void'(mq.pop_front());
`else
        m_irr = 1'b0;
`endif
    endfunction

    task automatic check_rx(input string tag);
        logic [31:0] er;
        logic        ei;
`ifdef UART_RX_FIFO_EN
        er = (mq.size() > 0) ? {24'h0, mq[0]} : 32'h0;
        ei = (mq.size() > 0);
`else
        er = {24'h0, m_r};
        ei = m_irr;
`endif
        check({tag, "_rdata"}, bus_if.r_data, er);
        check({tag, "_irr"}, 32'(bus_if.irr), 32'(ei));
    endtask

    task automatic do_ack();
        bus_if.ack = 1'b1;
        step(1);
        bus_if.ack = 1'b0;
        model_ack();
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            step(CPB);
        end
        uart_rx = 1'b1;
        step(6);
    endtask

    // Starts a write at the current cycle and follows the whole frame sample by sample.
    task automatic tx_frame(input logic [7:0] b, input bit hold, input logic [7:0] other);
        logic [9:0]  exp_bits;
        logic [9:0]  got_bits;
        logic [23:0] junk;
        int          bad;
        int          busy_n;
        exp_bits = {1'b1, b, 1'b0};
        got_bits = '0;
        bad      = 0;
        busy_n   = 0;
        junk     = 24'($urandom);
        bus_if.w_req  = 1'b1;
        bus_if.w_data = {junk, b};
        step(1);
        if (hold) bus_if.w_data = {24'h0, other};
        else      bus_if.w_req  = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (c == 70) bus_if.w_req = 1'b0;
            if (uart_tx !== exp_bits[c / 8]) bad++;
            if (c % 8 == 4) got_bits[c / 8] = uart_tx;
            if (bus_if.w_busy === 1'b1) busy_n++;
            step(1);
        end
        check("tx_bits", 32'(got_bits), 32'(exp_bits));
        check("tx_bit_width", 32'(bad), 32'd0);
        check("tx_busy_cycles", 32'(busy_n), 32'd80);
        check("tx_busy_drop", 32'(bus_if.w_busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 8'h5A, 1'b1, 32'h5A, 1'b1};
`ifdef UART_RX_FIFO_EN
        tbl[1] = '{1'b0, 8'h00, 1'b1, 32'h00, 1'b0};
        tbl[2] = '{1'b1, 8'h81, 1'b0, 32'h00, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 32'h00, 1'b0};
        tbl[4] = '{1'b1, 8'hC3, 1'b1, 32'hC3, 1'b1};
        tbl[5] = '{1'b1, 8'h3C, 1'b1, 32'hC3, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 32'h3C, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 32'h00, 1'b0};
`else
        tbl[1] = '{1'b0, 8'h00, 1'b1, 32'h5A, 1'b0};
        tbl[2] = '{1'b1, 8'h81, 1'b0, 32'h5A, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 32'h5A, 1'b0};
        tbl[4] = '{1'b1, 8'hC3, 1'b1, 32'hC3, 1'b1};
        tbl[5] = '{1'b1, 8'h3C, 1'b1, 32'h3C, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 32'h3C, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 32'h3C, 1'b0};
`endif

        rst           = 1'b1;
        uart_rx       = 1'b1;
        bus_if.w_req  = 1'b0;
        bus_if.w_data = '0;
        bus_if.ack    = 1'b0;
        model_reset();
        step(3);
        check("reset_tx", 32'(uart_tx), 32'd1);
        check("reset_busy", 32'(bus_if.w_busy), 32'd0);
        check("reset_irr", 32'(bus_if.irr), 32'd0);
        check("reset_rdata", bus_if.r_data, 32'd0);
        rst = 1'b0;
        step(2);

        uart_rx = 1'b0;
        step(2);
        uart_rx = 1'b1;
        step(20);
        check("glitch_irr", 32'(bus_if.irr), 32'd0);
        check("glitch_rdata", bus_if.r_data, 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].is_frame) rx_send(tbl[i].data, tbl[i].stop);
            else                 do_ack();
            check($sformatf("vec%0d_rdata", i), bus_if.r_data, tbl[i].exp_r);
            check($sformatf("vec%0d_irr", i), 32'(bus_if.irr), 32'(tbl[i].exp_irr));
        end

        for (int b = 1; b <= 5; b++) rx_send(8'(b), 1'b1);
`ifdef UART_RX_FIFO_EN
        for (int b = 1; b <= 4; b++) begin
            check($sformatf("fifo_head%0d", b), bus_if.r_data, 32'(b));
            check($sformatf("fifo_irr%0d", b), 32'(bus_if.irr), 32'd1);
            do_ack();
        end
        check("fifo_empty_irr", 32'(bus_if.irr), 32'd0);
        check("fifo_empty_rdata", bus_if.r_data, 32'd0);
`else
        check("overrun_rdata", bus_if.r_data, 32'h05);
        check("overrun_irr", 32'(bus_if.irr), 32'd1);
        do_ack();
        check("overrun_ack_irr", 32'(bus_if.irr), 32'd0);
        check("overrun_ack_rdata", bus_if.r_data, 32'h05);
`endif

        tx_frame(8'hA5, 1'b0, 8'h00);
        tx_frame(8'h5A, 1'b0, 8'h00);
        tx_frame(8'hA5, 1'b1, 8'h3C);
        step(10);
        check("tx_no_queue_busy", 32'(bus_if.w_busy), 32'd0);
        check("tx_no_queue_line", 32'(uart_tx), 32'd1);

        bus_if.w_req  = 1'b1;
        bus_if.w_data = 32'h0000_005A;
        uart_rx       = 1'b0;
        step(1);
        bus_if.w_req = 1'b0;
        step(30);
        check("pre_rst_tx", 32'(uart_tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", 32'(uart_tx), 32'd1);
        check("async_rst_busy", 32'(bus_if.w_busy), 32'd0);
        uart_rx = 1'b1;
        step(2);
        rst = 1'b0;
        model_reset();
        step(100);
        check_rx("post_rst_rx");
        tx_frame(8'hA5, 1'b0, 8'h00);

        for (int it = 0; it < 10; it++) begin
            logic [7:0] btx;
            logic [7:0] brx;
            logic       stp;
            btx = 8'($urandom);
            brx = 8'($urandom);
            stp = ($urandom_range(0, 4) != 0);
            fork
                tx_frame(btx, 1'b0, 8'h00);
                rx_send(brx, stp);
            join
            if (stp) model_rx(brx);
            check_rx($sformatf("rand%0d", it));
            if ($urandom_range(0, 1) == 1) begin
                do_ack();
                check_rx($sformatf("rand%0d_ack", it));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_uart_bridge.md
CPU_UART_BRIDGE -- requirements
Module: cpu_uart_bridge

Interface
- REQ-001: The block SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per UART bit (minimum 4).
- REQ-002: clk  input  1  system clock; all state updates on rising edge.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: w_req  input  1  CPU write request, sampled each cycle.
- REQ-005: w_data  input  32  CPU write data; bits [7:0] transmitted, [31:8] ignored.
- REQ-006: w_busy  output  1  transmitter occupied; CPU SHALL NOT expect acceptance while high.
- REQ-007: r_data  output  32  received byte, zero-extended to 32 bits.
- REQ-008: irr  output  1  receive-data-ready interrupt request, level.
- REQ-009: ack  input  1  one-cycle CPU acknowledge of r_data.
- REQ-010: uart_tx  output  1  serial line out, idle high.
- REQ-011: uart_rx  input  1  serial line in, asynchronous to clk.

Function
- REQ-012: TX FSM SHALL have states IDLE, START, DATA, STOP; the frame is 8N1, LSB first.
- REQ-013: w_req=1 with w_busy=0 in IDLE SHALL latch w_data[7:0]; next cycle: state=START, w_busy=1, uart_tx=0.
- REQ-014: w_req while w_busy=1 SHALL be ignored, with no queuing and no corruption of the frame in flight.
- REQ-015: Each TX state SHALL hold for exactly CLKS_PER_BIT cycles; DATA SHALL shift 8 bits via a 3-bit index.
- REQ-016: After STOP (uart_tx=1), TX SHALL return to IDLE and drop w_busy, so the frame takes 10*CLKS_PER_BIT cycles; a back-to-back w_req SHALL be accepted on the first cycle w_busy=0.
- REQ-017: uart_rx SHALL pass a 2-flop synchronizer before any use.
- REQ-018: RX FSM SHALL have states IDLE, START, DATA, STOP; a synchronized falling edge in IDLE SHALL enter START.
- REQ-019: At CLKS_PER_BIT/2 in START the line SHALL be resampled; if high (glitch), RX SHALL return to IDLE.
- REQ-020: Data bits SHALL be sampled at mid-bit, every CLKS_PER_BIT cycles thereafter.
- REQ-021: A stop bit sampled 1 SHALL complete the byte; r_data={24'h0,byte} and irr=1 on the following cycle.
- REQ-022: A stop bit sampled 0 (framing error) SHALL discard the byte, leave r_data and irr unchanged, and wait for the line to go high before IDLE.
- REQ-023: ack with irr=1 SHALL clear irr next cycle; ack with irr=0 SHALL have no effect; r_data SHALL hold its value after ack.
- REQ-024: Byte completion in the same cycle as ack SHALL leave irr=1 and r_data=new byte (the new byte wins).
- REQ-025: Without the FIFO, a new byte arriving while irr=1 SHALL overwrite r_data (overrun), and irr SHALL stay 1.
- REQ-026: TX and RX SHALL operate fully concurrently and independently.

Reset
- REQ-027: On rst: uart_tx=1, w_busy=0, irr=0, r_data=0, both FSMs IDLE, counters 0, synchronizer flops 1, FIFO empty.
- REQ-028: Reset mid-frame SHALL abort the frame immediately, with no partial byte delivered or completed.

Configuration
- REQ-029: With macro UART_RX_FIFO_EN defined, received bytes SHALL enter a 4-entry FIFO.
- REQ-030: In FIFO mode, r_data = head entry (0 when empty), irr = !empty, ack pops the head, and a byte arriving when full SHALL be dropped.
- REQ-031: In FIFO mode, simultaneous push and pop SHALL both take effect, with the count unchanged.
- REQ-032: Without UART_RX_FIFO_EN, the single holding register behaviour of REQ-021..025 SHALL apply.

Structure
- REQ-033: Package lib_uart SHALL hold the UART_STATE enum (IDLE/START/DATA/STOP), the frame bit count (8), and the FIFO depth (4).
- REQ-034: The RX deserializer SHALL be sub-module uart_rx (synchronizer, FSM, byte-valid strobe); TX, FIFO, and CPU handshake SHALL live in cpu_uart_bridge.

Verification (CLKS_PER_BIT=8)
- REQ-035: w_req, w_data=32'h0000_00A5 -> uart_tx bits 0,1,0,1,0,0,1,0,1,1, each 8 cycles; w_busy high exactly 80 cycles.
- REQ-036: w_req held during a frame with w_data=8'h3C -> ignored; only 8'hA5 transmitted.
- REQ-037: Drive 8'h5A frame on uart_rx -> r_data=32'h0000_005A, irr=1; ack pulse -> irr=0 next cycle, r_data unchanged.
- REQ-038: 2-cycle low glitch on uart_rx -> no irr; 8'h81 frame with stop=0 -> irr stays 0, r_data unchanged.
- REQ-039: FIFO build: 5 bytes 01..05 without ack -> reads 01,02,03,04 via ack; 05 dropped; irr=0 after 4th ack. Non-FIFO build: 05 visible, irr=1.
- REQ-040: rst asserted mid-TX-frame -> uart_tx=1 and w_busy=0 asynchronously; a new w_req after release transmits a clean frame.
